// File: rtl/song_recorder.sv
// song_recorder: records a session of note entries into a register array and
// plays them back one at a time through an external sound player.
//
// Ports
//   clk, rst_n                : clock and synchronous active-low reset
//   en                        : block enable; low returns to idle, keeps contents
//   rec, play, stop           : single-cycle command pulses
//   hit                       : note entry valid (octave_in, note_in, length_in)
//   over                      : sound-player done flag (high = idle/finished)
//   start                     : one-cycle launch pulse for the sound player
//   octave, note, length      : playback entry presented to the sound player
//   count, full               : stored entries (0..DEPTH) and count == DEPTH
//   recording, playing        : session status
//
// Configuration
//   RECORDER_LOOP_EN : when defined, playback wraps from the last entry back to
//                      entry 0 and continues until stop or en low.

`ifndef OCTAVE_BITS
`define OCTAVE_BITS 3
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 4
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 3
`endif

module song_recorder #(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ADDR_BITS = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    rec,
    input  logic                    play,
    input  logic                    stop,
    input  logic                    hit,
    input  logic [`OCTAVE_BITS-1:0] octave_in,
    input  logic [`NOTE_BITS-1:0]   note_in,
    input  logic [`LENGTH_BITS-1:0] length_in,
    input  logic                    over,
    output logic                    start,
    output logic [`OCTAVE_BITS-1:0] octave,
    output logic [`NOTE_BITS-1:0]   note,
    output logic [`LENGTH_BITS-1:0] length,
    output logic [ADDR_BITS:0]      count,
    output logic                    full,
    output logic                    recording,
    output logic                    playing
);

    localparam int unsigned EntryBits = `OCTAVE_BITS + `NOTE_BITS + `LENGTH_BITS;

`ifdef RECORDER_LOOP_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRec,
        StPlayIssue,
        StPlayAck,
        StPlayWait
    } state_e;

    state_e                 state_q;
    logic [ADDR_BITS-1:0]   rd_idx_q;
    logic [EntryBits-1:0]   mem_q [DEPTH];

    logic                   wr_en;
    logic                   last_entry;
    logic [ADDR_BITS-1:0]   next_idx;
    logic [EntryBits-1:0]   first_entry;
    logic [EntryBits-1:0]   next_entry;

    assign full      = (count == (ADDR_BITS + 1)'(DEPTH));
    assign recording = (state_q == StRec);
    assign playing   = (state_q == StPlayIssue) || (state_q == StPlayAck) ||
                       (state_q == StPlayWait);

    // A hit is stored only while recording with room left; a hit coincident
    // with stop still lands.
    assign wr_en      = rst_n && en && (state_q == StRec) && hit && !full;
    assign last_entry = ({1'b0, rd_idx_q} == (count - 1'b1));
    assign next_idx   = (last_entry && LoopEn) ? '0 : rd_idx_q + 1'b1;
    assign first_entry = mem_q[0];
    assign next_entry  = mem_q[next_idx];

    // Note storage is deliberately not reset; count alone defines validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count[ADDR_BITS-1:0]] <= {octave_in, note_in, length_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count    <= '0;
            rd_idx_q <= '0;
            start    <= 1'b0;
            octave   <= `OCTAVE_BITS'(4);
            note     <= '0;
            length   <= '0;
        end else if (!en) begin
            state_q <= StIdle;
            start   <= 1'b0;
        end else begin
            start <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rec) begin
                        state_q <= StRec;
                        count   <= '0;
                    end else if (play && (count != '0)) begin
                        // Entry and start are registered together so the
                        // player sees valid outputs while start is high.
                        rd_idx_q                <= '0;
                        {octave, note, length}  <= first_entry;
                        start                   <= 1'b1;
                        state_q                 <= StPlayIssue;
                    end
                end
                StRec: begin
                    if (wr_en) begin
                        count <= count + 1'b1;
                    end
                    if (stop) begin
                        state_q <= StIdle;
                    end
                end
                StPlayIssue: begin
                    state_q <= stop ? StIdle : StPlayAck;
                end
                StPlayAck: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end else if (!over) begin
                        state_q <= StPlayWait;
                    end
                end
                StPlayWait: begin
                    if (stop) begin
                        state_q <= StIdle;
                    end else if (over) begin
                        if (last_entry && !LoopEn) begin
                            state_q <= StIdle;
                        end else begin
                            rd_idx_q               <= next_idx;
                            {octave, note, length} <= next_entry;
                            start                  <= 1'b1;
                            state_q                <= StPlayIssue;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: a queue-based reference model of the
// recorded song feeds expected playback entries; a monitor compares every
// start pulse against the head of the expected queue.

`ifndef OCTAVE_BITS
`define OCTAVE_BITS 3
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 4
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 3
`endif

module tb_song_recorder;

    localparam int DEPTH     = 32;
    localparam int ADDR_BITS = 5;
    localparam int OB        = `OCTAVE_BITS;
    localparam int NB        = `NOTE_BITS;
    localparam int LB        = `LENGTH_BITS;

    typedef struct packed {
        logic [OB-1:0] o;
        logic [NB-1:0] n;
        logic [LB-1:0] l;
    } entry_t;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              rec;
    logic              play;
    logic              stop;
    logic              hit;
    logic [OB-1:0]     octave_in;
    logic [NB-1:0]     note_in;
    logic [LB-1:0]     length_in;
    logic              over;
    logic              start;
    logic [OB-1:0]     octave;
    logic [NB-1:0]     note;
    logic [LB-1:0]     length;
    logic [ADDR_BITS:0] count;
    logic              full;
    logic              recording;
    logic              playing;

    song_recorder #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rec       (rec),
        .play      (play),
        .stop      (stop),
        .hit       (hit),
        .octave_in (octave_in),
        .note_in   (note_in),
        .length_in (length_in),
        .over      (over),
        .start     (start),
        .octave    (octave),
        .note      (note),
        .length    (length),
        .count     (count),
        .full      (full),
        .recording (recording),
        .playing   (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     tests;
    int     fails;
    int     starts_seen;
    entry_t exp_q[$];
    entry_t model_q[$];
    bit     model_rec;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every start pulse must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && start) begin
            starts_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                check("start_entry", int'({octave, note, length}), int'(e));
            end
        end
    end

    // Sound-player model: over drops one cycle after start, rises 10 later.
    initial begin
        over = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && start) begin
                @(posedge clk);
                #1 over = 1'b0;
                repeat (10) @(posedge clk);
                #1 over = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_rec();
        rec = 1'b1;
        tick();
        rec = 1'b0;
        model_q.delete();
        model_rec = 1'b1;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        model_rec = 1'b0;
    endtask

    task automatic do_hit(input entry_t e, input bit with_stop);
        hit       = 1'b1;
        stop      = with_stop;
        octave_in = e.o;
        note_in   = e.n;
        length_in = e.l;
        tick();
        hit  = 1'b0;
        stop = 1'b0;
        if (model_rec && model_q.size() < DEPTH) model_q.push_back(e);
        if (with_stop) model_rec = 1'b0;
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e.o = OB'($urandom);
        e.n = NB'($urandom);
        e.l = LB'($urandom);
        return e;
    endfunction

    task automatic wait_starts(input int target, input string name);
        int budget;
        budget = 2000;
        while (starts_seen < target && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) check(name, starts_seen, target);
    endtask

    // Plays back the model song and checks it appears in order.
    task automatic play_check(input string name);
        int base;
        base = starts_seen;
`ifdef RECORDER_LOOP_EN
        for (int r = 0; r < 2; r++) begin
            foreach (model_q[i]) exp_q.push_back(model_q[i]);
        end
`else
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
`endif
        play = 1'b1;
        tick();
        play = 1'b0;
        check({name, "_latency_start"}, int'(start), 1);
`ifdef RECORDER_LOOP_EN
        wait_starts(base + 2 * model_q.size(), {name, "_loop_timeout"});
        do_stop();
`else
        begin
            int budget;
            budget = 20 * model_q.size() + 50;
            while (playing && budget > 0) begin
                tick();
                budget--;
            end
            check({name, "_done_timeout"}, int'(budget > 0), 1);
        end
`endif
        check({name, "_playing_low"}, int'(playing), 0);
        repeat (15) tick();
        check({name, "_all_entries"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        entry_t e;
        int     n;
        int     base;

        tests = 0; fails = 0; starts_seen = 0; model_rec = 1'b0;
        rst_n = 1'b0; en = 1'b1; rec = 1'b0; play = 1'b0; stop = 1'b0; hit = 1'b0;
        octave_in = '0; note_in = '0; length_in = '0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_count", int'(count), 0);
        check("rst_full", int'(full), 0);
        check("rst_start", int'(start), 0);
        check("rst_octave", int'(octave), 4);
        check("rst_note", int'(note), 0);
        check("rst_length", int'(length), 0);
        check("rst_recording", int'(recording), 0);
        check("rst_playing", int'(playing), 0);

        // Directed three-note song
        do_rec();
        check("rec_recording", int'(recording), 1);
        check("rec_count_clear", int'(count), 0);
        e = '{o: 4, n: 1, l: 2}; do_hit(e, 1'b0);
        e = '{o: 4, n: 3, l: 1}; do_hit(e, 1'b0);
        e = '{o: 5, n: 5, l: 4}; do_hit(e, 1'b0);
        do_stop();
        check("dir_count", int'(count), 3);
        check("dir_full", int'(full), 0);
        check("dir_recording", int'(recording), 0);
        play_check("dir_play");

        // Randomized songs, last hit coincident with stop
        for (int r = 0; r < 3; r++) begin
            do_rec();
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                do_hit(rand_entry(), 1'b0);
                repeat ($urandom_range(0, 2)) tick();
            end
            do_hit(rand_entry(), 1'b1);
            check("rnd_count", int'(count), model_q.size());
            play_check("rnd_play");
        end

        // Overfill: 33 hits into 32 slots
        do_rec();
        for (int i = 0; i < DEPTH + 1; i++) do_hit(rand_entry(), 1'b0);
        check("full_count", int'(count), DEPTH);
        check("full_flag", int'(full), 1);
        do_stop();
        play_check("full_play");

        // Empty song: play does nothing
        do_rec();
        do_stop();
        check("empty_count", int'(count), 0);
        play = 1'b1;
        tick();
        play = 1'b0;
        repeat (5) tick();
        check("empty_playing", int'(playing), 0);

        // rec and play together: rec wins
        rec = 1'b1; play = 1'b1;
        tick();
        rec = 1'b0; play = 1'b0;
        model_q.delete(); model_rec = 1'b1;
        check("recplay_recording", int'(recording), 1);
        check("recplay_playing", int'(playing), 0);
        for (int i = 0; i < 3; i++) do_hit(rand_entry(), 1'b0);
        do_stop();

        // Stop while waiting on the second entry
        base = starts_seen;
        exp_q.push_back(model_q[0]);
        exp_q.push_back(model_q[1]);
        play = 1'b1;
        tick();
        play = 1'b0;
        wait_starts(base + 2, "stopwait_timeout");
        begin
            int budget;
            budget = 20;
            while (over && budget > 0) begin
                tick();
                budget--;
            end
        end
        tick(); tick();
        do_stop();
        check("stopwait_playing", int'(playing), 0);
        repeat (25) tick();
        check("stopwait_no_more", exp_q.size(), 0);
        check("stopwait_count", int'(count), 3);
        exp_q.delete();

        // en low aborts playback, keeps contents; hit outside REC ignored
        base = starts_seen;
        exp_q.push_back(model_q[0]);
        play = 1'b1;
        tick();
        play = 1'b0;
        wait_starts(base + 1, "en_timeout");
        tick();
        en = 1'b0;
        tick();
        check("en_playing", int'(playing), 0);
        check("en_start", int'(start), 0);
        en = 1'b1;
        do_hit(rand_entry(), 1'b0);
        check("en_count_kept", int'(count), 3);
        repeat (15) tick();
        check("en_no_more", exp_q.size(), 0);
        exp_q.delete();
        play_check("en_replay");

        // Reset mid-record abandons session
        do_rec();
        do_hit(rand_entry(), 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_q.delete(); model_rec = 1'b0;
        check("midrst_count", int'(count), 0);
        check("midrst_recording", int'(recording), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
